// File: rtl/pulse_expand.sv
// pulse_expand: measures each high run on `in` and then emits one `out` pulse RATIO x as long.
// Latency: a run ending in cycle C (first low sample) drives out high from cycle C+2.
// Backpressure: none upstream; a run captured while the 1-deep buffer is held is discarded and flagged on drop.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset
//   in       serial input; a high run of N cycles encodes length N (saturates at MAX_IN)
//   out      registered expanded pulse, RATIO*N cycles long
//   busy     registered; emitter not idle or pending buffer valid (run measurement not included)
//   drop     registered one-cycle strobe when a captured run is discarded
//   drop_cnt saturating 8-bit drop count, present only with PULSE_EXPAND_DROP_CNT_EN defined
module pulse_expand #(
    parameter int RATIO  = 4,
    parameter int MAX_IN = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    output logic       out,
    output logic       busy,
    output logic       drop
`ifdef PULSE_EXPAND_DROP_CNT_EN
    ,
    output logic [7:0] drop_cnt
`endif
);

    localparam int MW = $clog2(MAX_IN + 1);
    localparam int OW = $clog2(RATIO * MAX_IN + 1);

    localparam logic [0:0] M_IDLE  = 1'b0;
    localparam logic [0:0] M_COUNT = 1'b1;

    localparam logic [1:0] E_IDLE = 2'd0;
    localparam logic [1:0] E_RUN  = 2'd1;
    localparam logic [1:0] E_GAP  = 2'd2;

    logic [0:0]    r_m_state, w_m_state_nxt;
    logic [MW-1:0] r_mcnt,    w_mcnt_nxt;
    logic [1:0]    r_e_state, w_e_state_nxt;
    logic [OW-1:0] r_ocnt,    w_ocnt_nxt;
    logic          r_pend_vld, w_pend_vld_nxt;
    logic [MW-1:0] r_pend_len, w_pend_len_nxt;
    logic          r_out, r_busy, r_drop;
    logic          w_drop_nxt;
    logic          w_capture;
    logic          w_load;
    logic [OW-1:0] w_load_len;

    // Measure side: count the high run, capture its length on the first low cycle.
    always_comb begin
        w_m_state_nxt = r_m_state;
        w_mcnt_nxt    = r_mcnt;
        w_capture     = 1'b0;
        case (r_m_state)
            M_IDLE: begin
                if (in) begin
                    w_m_state_nxt = M_COUNT;
                    w_mcnt_nxt    = MW'(1);
                end
            end
            default: begin
                if (in) begin
                    // Saturate rather than wrap so over-long runs emit the maximum pulse.
                    if (r_mcnt != MW'(MAX_IN))
                        w_mcnt_nxt = r_mcnt + MW'(1);
                end else begin
                    w_capture     = 1'b1;
                    w_m_state_nxt = M_IDLE;
                    w_mcnt_nxt    = '0;
                end
            end
        endcase
    end

    // The product fits in OW bits because pend_len never exceeds MAX_IN.
    assign w_load     = r_pend_vld && ((r_e_state == E_IDLE) || (r_e_state == E_GAP));
    assign w_load_len = OW'(r_pend_len) * OW'(RATIO);

    // Emit side: E_RUN holds out high for ocnt cycles, E_GAP forces one low cycle.
    always_comb begin
        w_e_state_nxt = r_e_state;
        w_ocnt_nxt    = r_ocnt;
        if (w_load) begin
            w_e_state_nxt = E_RUN;
            w_ocnt_nxt    = w_load_len;
        end else begin
            case (r_e_state)
                E_RUN: begin
                    if (r_ocnt == OW'(1)) begin
                        w_e_state_nxt = E_GAP;
                        w_ocnt_nxt    = '0;
                    end else begin
                        w_ocnt_nxt = r_ocnt - OW'(1);
                    end
                end
                default: w_e_state_nxt = E_IDLE;
            endcase
        end
    end

    // Pending buffer: a capture lands in the buffer if it is empty or being
    // drained into the emitter this same cycle; otherwise the new run is lost.
    always_comb begin
        w_pend_vld_nxt = r_pend_vld;
        w_pend_len_nxt = r_pend_len;
        w_drop_nxt     = 1'b0;
        if (w_load)
            w_pend_vld_nxt = 1'b0;
        if (w_capture) begin
            if (!r_pend_vld || w_load) begin
                w_pend_vld_nxt = 1'b1;
                w_pend_len_nxt = r_mcnt;
            end else begin
                w_drop_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m_state  <= M_IDLE;
            r_mcnt     <= '0;
            r_e_state  <= E_IDLE;
            r_ocnt     <= '0;
            r_pend_vld <= 1'b0;
            r_pend_len <= '0;
            r_out      <= 1'b0;
            r_busy     <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_m_state  <= w_m_state_nxt;
            r_mcnt     <= w_mcnt_nxt;
            r_e_state  <= w_e_state_nxt;
            r_ocnt     <= w_ocnt_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend_len <= w_pend_len_nxt;
            // Outputs are registered from next-state so they line up with the state they describe.
            r_out      <= (w_e_state_nxt == E_RUN);
            r_busy     <= (w_e_state_nxt != E_IDLE) || w_pend_vld_nxt;
            r_drop     <= w_drop_nxt;
        end
    end

    assign out  = r_out;
    assign busy = r_busy;
    assign drop = r_drop;

`ifdef PULSE_EXPAND_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_drop_cnt <= 8'd0;
        else if (w_drop_nxt && (r_drop_cnt != 8'hFF))
            r_drop_cnt <= r_drop_cnt + 8'd1;
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_pulse_expand.sv
// tb_pulse_expand: drives runs on `in` and compares out/busy/drop each cycle against an interval model.
// Latency: model predicts the registered outputs for the cycle after each driven input.
// Backpressure: n/a.
module tb_pulse_expand;

    localparam int RATIO  = 4;
    localparam int MAX_IN = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic in_s  = 1'b0;
    logic out_s, busy_s, drop_s;
`ifdef PULSE_EXPAND_DROP_CNT_EN
    logic [7:0] dcnt_s;
`endif

    always #5 clk = ~clk;

    pulse_expand #(.RATIO(RATIO), .MAX_IN(MAX_IN)) dut (
        .clk   (clk),
        .reset (reset),
        .in    (in_s),
        .out   (out_s),
        .busy  (busy_s),
        .drop  (drop_s)
`ifdef PULSE_EXPAND_DROP_CNT_EN
        ,
        .drop_cnt (dcnt_s)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: a run is a count of consecutive ones; an emitted pulse
    // is an interval [m_lo, m_hi] of out-high cycles, and the emitter can take
    // the next pending run from cycle m_next (the single gap cycle) onwards.
    int m_run, m_pl, m_lo, m_hi, m_next, e_dcnt;
    bit m_pv;
    bit e_out, e_busy, e_drop;

    bit obs_q[$];
    int wq[$];
    bit stim[$];

    task automatic model_reset();
        m_run = 0; m_pv = 0; m_pl = 0;
        m_lo = 1; m_hi = 0; m_next = 0;
        e_dcnt = 0;
        e_out = 0; e_busy = 0; e_drop = 0;
    endtask

    // Drive one input cycle, advance the model, and land #1 after the edge.
    task automatic step(input bit v);
        bit load, was_pv;
        in_s   = v;
        was_pv = m_pv;
        load   = m_pv && (cyc >= m_next);
        e_drop = 0;
        if (load) begin
            m_lo   = cyc + 1;
            m_hi   = cyc + m_pl * RATIO;
            m_next = m_hi + 1;
            m_pv   = 0;
        end
        if (!v && m_run > 0) begin
            if (!was_pv || load) begin
                m_pv = 1;
                m_pl = (m_run > MAX_IN) ? MAX_IN : m_run;
            end else begin
                e_drop = 1;
                if (e_dcnt < 255) e_dcnt++;
            end
        end
        m_run  = v ? m_run + 1 : 0;
        e_out  = (cyc + 1 >= m_lo) && (cyc + 1 <= m_hi);
        e_busy = m_pv || ((cyc + 1 >= m_lo) && (cyc + 1 <= m_next));
        @(posedge clk);
        #1;
        cyc++;
        obs_q.push_back(out_s);
    endtask

    function automatic void calc_widths();
        int run;
        run = 0;
        wq.delete();
        foreach (obs_q[i]) begin
            if (obs_q[i]) run++;
            else if (run > 0) begin wq.push_back(run); run = 0; end
        end
        if (run > 0) wq.push_back(run);
    endfunction

    task automatic test_reset();
        in_s = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if ({out_s, busy_s, drop_s} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs out/busy/drop got %b%b%b exp 000", out_s, busy_s, drop_s);
        end
`ifdef PULSE_EXPAND_DROP_CNT_EN
        checks++;
        if (dcnt_s !== 8'd0) begin
            errors++;
            $display("FAIL reset_drop_cnt got %0d exp 0", dcnt_s);
        end
`endif
        in_s  = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        cyc = 0;
        repeat (3) begin
            step(0);
            checks++;
            if ({out_s, busy_s, drop_s} !== 3'b000) begin
                errors++;
                $display("FAIL post_reset_idle out/busy/drop got %b%b%b exp 000", out_s, busy_s, drop_s);
            end
        end
    endtask

    // Single runs of 3, 1 and 10 (saturating) cycles.
    task automatic test_single();
        int lens[3] = '{3, 1, 10};
        int first_hi;
        stim.delete(); obs_q.delete();
        foreach (lens[k]) begin
            repeat (lens[k]) stim.push_back(1);
            repeat (40) stim.push_back(0);
        end
        foreach (stim[i]) begin
            step(stim[i]);
            checks++;
            if ({out_s, busy_s, drop_s} !== {e_out, e_busy, e_drop}) begin
                errors++;
                $display("FAIL single cyc=%0d out/busy/drop got %b%b%b exp %b%b%b",
                         cyc, out_s, busy_s, drop_s, e_out, e_busy, e_drop);
            end
        end
        // First run's capture cycle is index 3; out must rise at cycle 5 (obs index 4).
        first_hi = -1;
        foreach (obs_q[i]) if (first_hi < 0 && obs_q[i]) first_hi = i;
        checks++;
        if (first_hi !== 4) begin
            errors++;
            $display("FAIL single_latency first high obs got %0d exp 4", first_hi);
        end
        calc_widths();
        checks++;
        if (wq.size() !== 3) begin
            errors++;
            $display("FAIL single_count pulses got %0d exp 3", wq.size());
        end else begin
            foreach (lens[k]) begin
                checks++;
                if (wq[k] !== RATIO * ((lens[k] > MAX_IN) ? MAX_IN : lens[k])) begin
                    errors++;
                    $display("FAIL single_width run=%0d got %0d exp %0d", lens[k], wq[k],
                             RATIO * ((lens[k] > MAX_IN) ? MAX_IN : lens[k]));
                end
            end
        end
    endtask

    // Runs 2, low 1, 2: two 8-cycle pulses separated by exactly one low cycle.
    task automatic test_back_to_back();
        int nd, first_hi, second_hi;
        nd = 0;
        stim = '{1, 1, 0, 1, 1};
        repeat (30) stim.push_back(0);
        obs_q.delete();
        foreach (stim[i]) begin
            step(stim[i]);
            if (drop_s) nd++;
            checks++;
            if ({out_s, busy_s, drop_s} !== {e_out, e_busy, e_drop}) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d out/busy/drop got %b%b%b exp %b%b%b",
                         cyc, out_s, busy_s, drop_s, e_out, e_busy, e_drop);
            end
        end
        calc_widths();
        checks++;
        if (wq.size() !== 2 || wq[0] !== 8 || wq[1] !== 8) begin
            errors++;
            $display("FAIL b2b_widths got n=%0d w0=%0d w1=%0d exp 2,8,8", wq.size(),
                     (wq.size() > 0) ? wq[0] : -1, (wq.size() > 1) ? wq[1] : -1);
        end
        first_hi = -1; second_hi = -1;
        foreach (obs_q[i]) begin
            if (first_hi < 0 && obs_q[i]) first_hi = i;
            else if (first_hi >= 0 && second_hi < 0 && i > first_hi + 8 && obs_q[i]) second_hi = i;
        end
        checks++;
        if (second_hi - first_hi !== 9) begin
            errors++;
            $display("FAIL b2b_gap start spacing got %0d exp 9", second_hi - first_hi);
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL b2b_drop strobes got %0d exp 0", nd);
        end
    endtask

    // Run 6, then two 1-cycle runs during emission: second emitted, third dropped.
    task automatic test_drop();
        int nd;
        nd = 0;
        stim = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1};
        repeat (40) stim.push_back(0);
        obs_q.delete();
`ifdef PULSE_EXPAND_DROP_CNT_EN
        e_dcnt = dcnt_s;
`endif
        foreach (stim[i]) begin
            step(stim[i]);
            if (drop_s) nd++;
            checks++;
            if ({out_s, busy_s, drop_s} !== {e_out, e_busy, e_drop}) begin
                errors++;
                $display("FAIL drop cyc=%0d out/busy/drop got %b%b%b exp %b%b%b",
                         cyc, out_s, busy_s, drop_s, e_out, e_busy, e_drop);
            end
        end
        calc_widths();
        checks++;
        if (wq.size() !== 2 || wq[0] !== 24 || wq[1] !== 4) begin
            errors++;
            $display("FAIL drop_widths got n=%0d w0=%0d w1=%0d exp 2,24,4", wq.size(),
                     (wq.size() > 0) ? wq[0] : -1, (wq.size() > 1) ? wq[1] : -1);
        end
        checks++;
        if (nd !== 1) begin
            errors++;
            $display("FAIL drop_strobes got %0d exp 1", nd);
        end
`ifdef PULSE_EXPAND_DROP_CNT_EN
        checks++;
        if (dcnt_s !== 8'd1) begin
            errors++;
            $display("FAIL drop_cnt got %0d exp 1", dcnt_s);
        end
`endif
    endtask

    // Third run's capture lands on the gap cycle where the second run reloads.
    task automatic test_gap_reload();
        int nd;
        nd = 0;
        stim = '{1, 0, 0, 1, 0, 1, 1, 0};
        repeat (30) stim.push_back(0);
        obs_q.delete();
        foreach (stim[i]) begin
            step(stim[i]);
            if (drop_s) nd++;
            checks++;
            if ({out_s, busy_s, drop_s} !== {e_out, e_busy, e_drop}) begin
                errors++;
                $display("FAIL gap_reload cyc=%0d out/busy/drop got %b%b%b exp %b%b%b",
                         cyc, out_s, busy_s, drop_s, e_out, e_busy, e_drop);
            end
        end
        calc_widths();
        checks++;
        if (wq.size() !== 3 || wq[0] !== 4 || wq[1] !== 4 || wq[2] !== 8) begin
            errors++;
            $display("FAIL gap_reload_widths got n=%0d exp 3 pulses 4,4,8", wq.size());
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL gap_reload_drop strobes got %0d exp 0", nd);
        end
    endtask

    // Async reset in the middle of an emitted pulse, then a clean 2-cycle run.
    task automatic test_reset_mid();
        stim = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        foreach (stim[i]) step(stim[i]);
        checks++;
        if (out_s !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre out got %b exp 1", out_s);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({out_s, busy_s, drop_s} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_async out/busy/drop got %b%b%b exp 000", out_s, busy_s, drop_s);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        stim = '{1, 1, 0};
        repeat (20) stim.push_back(0);
        obs_q.delete();
        foreach (stim[i]) begin
            step(stim[i]);
            checks++;
            if ({out_s, busy_s, drop_s} !== {e_out, e_busy, e_drop}) begin
                errors++;
                $display("FAIL reset_mid_after cyc=%0d out/busy/drop got %b%b%b exp %b%b%b",
                         cyc, out_s, busy_s, drop_s, e_out, e_busy, e_drop);
            end
        end
        calc_widths();
        checks++;
        if (wq.size() !== 1 || wq[0] !== 8) begin
            errors++;
            $display("FAIL reset_mid_width got n=%0d w0=%0d exp 1,8", wq.size(),
                     (wq.size() > 0) ? wq[0] : -1);
        end
    endtask

    // Random run lengths and gaps, including overlaps that reload and drop.
    task automatic test_random();
        stim.delete();
        repeat (30) begin
            repeat ($urandom_range(1, 9)) stim.push_back(1);
            repeat ($urandom_range(1, 14)) stim.push_back(0);
        end
        repeat (40) stim.push_back(0);
        foreach (stim[i]) begin
            step(stim[i]);
            checks++;
            if ({out_s, busy_s, drop_s} !== {e_out, e_busy, e_drop}) begin
                errors++;
                $display("FAIL random cyc=%0d out/busy/drop got %b%b%b exp %b%b%b",
                         cyc, out_s, busy_s, drop_s, e_out, e_busy, e_drop);
            end
`ifdef PULSE_EXPAND_DROP_CNT_EN
            checks++;
            if (dcnt_s !== 8'(e_dcnt)) begin
                errors++;
                $display("FAIL random_drop_cnt cyc=%0d got %0d exp %0d", cyc, dcnt_s, e_dcnt);
            end
`endif
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_drop();
        test_gap_reload();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
